// File: rtl/des_block_controller.sv
// Job sequencer for one des_block counting engine: accepts a job, loads and starts
// the block, waits for done or watchdog expiry, returns the count and restarts the block.
module des_block_controller #(
    parameter logic [31:0] TIMEOUT = 32'hFFFF_FFFF,
    parameter int          ID_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             job_valid,
    output logic             job_ready,
    input  logic [ID_W-1:0]  job_id,
    input  logic [63:0]      job_seed,
    input  logic [63:0]      job_polynomial,
    input  logic [63:0]      job_mask_i,
    input  logic [63:0]      job_mask_o,
    input  logic [63:0]      job_limit,
    input  logic [767:0]     job_round_keys,

    output logic             blk_start,
    output logic             blk_restart,
    output logic [63:0]      blk_seed,
    output logic [63:0]      blk_polynomial,
    output logic [63:0]      blk_mask_i,
    output logic [63:0]      blk_mask_o,
    output logic [63:0]      blk_limit,
    output logic [767:0]     blk_round_keys,
    input  logic [63:0]      blk_counter,
    input  logic             blk_done,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [ID_W-1:0]  res_id,
    output logic [63:0]      res_counter,
    output logic [31:0]      res_cycles,
    output logic             res_timeout,

    output logic             busy,
    output logic [31:0]      jobs_done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_RESULT = 3'd4,
        ST_CLEAR  = 3'd5
    } state_t;

    state_t            r_state;
    logic              r_job_ready;
    logic              r_busy;
    logic              r_blk_start;
    logic              r_blk_restart;
    logic              r_res_valid;
    logic [63:0]       r_seed;
    logic [63:0]       r_polynomial;
    logic [63:0]       r_mask_i;
    logic [63:0]       r_mask_o;
    logic [63:0]       r_limit;
    logic [767:0]      r_round_keys;
    logic [ID_W-1:0]   r_res_id;
    logic [63:0]       r_res_counter;
    logic [31:0]       r_res_cycles;
    logic              r_res_timeout;
    logic [31:0]       r_cycles;
    logic [31:0]       r_jobs_done;

    logic [31:0]       w_cycles_next;
    logic              w_job_accept;
    logic              w_zero_limit;

    assign w_cycles_next = r_cycles + 32'd1;
    assign w_job_accept  = job_valid & r_job_ready;
    assign w_zero_limit  = (job_limit == 64'd0);

    // Control outputs are registered for the state being entered, so each one is
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_job_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_blk_start   <= 1'b0;
            r_blk_restart <= 1'b0;
            r_res_valid   <= 1'b0;
            r_seed        <= '0;
            r_polynomial  <= '0;
            r_mask_i      <= '0;
            r_mask_o      <= '0;
            r_limit       <= '0;
            r_round_keys  <= '0;
            r_res_id      <= '0;
            r_res_counter <= '0;
            r_res_cycles  <= '0;
            r_res_timeout <= 1'b0;
            r_cycles      <= '0;
            r_jobs_done   <= '0;
        end else begin
            r_blk_start   <= 1'b0;
            r_blk_restart <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_job_accept) begin
                        r_seed       <= job_seed;
                        r_polynomial <= job_polynomial;
                        r_mask_i     <= job_mask_i;
                        r_mask_o     <= job_mask_o;
                        r_limit      <= job_limit;
                        r_round_keys <= job_round_keys;
                        r_res_id     <= job_id;
                        r_job_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        if (w_zero_limit) begin
                            // Nothing to count: report an empty result without starting the block.
                            r_res_counter <= '0;
                            r_res_cycles  <= '0;
                            r_res_timeout <= 1'b0;
                            r_res_valid   <= 1'b1;
                            r_state       <= ST_RESULT;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_blk_start <= 1'b1;
                    r_state     <= ST_START;
                end
                ST_START: begin
                    r_cycles <= '0;
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    r_cycles <= w_cycles_next;
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (blk_done) begin
                        r_res_counter <= blk_counter;
                        r_res_cycles  <= w_cycles_next;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_RESULT;
                    end else if (w_cycles_next == TIMEOUT) begin
                        r_res_counter <= blk_counter;
                        r_res_cycles  <= w_cycles_next;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                        r_state       <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        r_jobs_done   <= r_jobs_done + 32'd1;
                        r_res_valid   <= 1'b0;
                        r_blk_restart <= 1'b1;
                        r_state       <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_job_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_job_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_res_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign job_ready      = r_job_ready;
    assign busy           = r_busy;
    assign blk_start      = r_blk_start;
    assign blk_restart    = r_blk_restart;
    assign blk_seed       = r_seed;
    assign blk_polynomial = r_polynomial;
    assign blk_mask_i     = r_mask_i;
    assign blk_mask_o     = r_mask_o;
    assign blk_limit      = r_limit;
    assign blk_round_keys = r_round_keys;
    assign res_valid      = r_res_valid;
    assign res_id         = r_res_id;
    assign res_counter    = r_res_counter;
    assign res_cycles     = r_res_cycles;
    assign res_timeout    = r_res_timeout;
    assign jobs_done      = r_jobs_done;

endmodule

// File: tb/tb_des_block_controller.sv
// Scoreboard bench for des_block_controller: one instance with the default watchdog,
// one with TIMEOUT=16, each driven by a small des_block behavioural model.
module tb_des_block_controller;

    logic         clk;
    logic         rst_n;
    logic [7:0]   job_id;
    logic [63:0]  job_seed, job_polynomial, job_mask_i, job_mask_o, job_limit;
    logic [767:0] job_round_keys;

    logic         job_valid [2];
    logic         job_ready [2];
    logic         res_ready [2];
    logic         blk_start [2];
    logic         blk_restart [2];
    logic [63:0]  blk_seed [2];
    logic [63:0]  blk_poly [2];
    logic [63:0]  blk_mask_i [2];
    logic [63:0]  blk_mask_o [2];
    logic [63:0]  blk_limit [2];
    logic [767:0] blk_rk [2];
    logic [63:0]  blk_counter [2];
    logic         blk_done [2];
    logic         res_valid [2];
    logic [7:0]   res_id [2];
    logic [63:0]  res_counter [2];
    logic [31:0]  res_cycles [2];
    logic         res_timeout [2];
    logic         busy [2];
    logic [31:0]  jobs_done [2];

    typedef struct {
        logic [7:0]  id;
        logic [63:0] counter;
        logic [31:0] cycles;
        logic        timeout;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cnt [2];
    int start_cyc [2];
    int restart_cnt [2];
    int exp_jobs [2];
    int done_at [2];
    int run_k [2];
    logic [63:0] cnt_val [2];

    des_block_controller #(.TIMEOUT(32'hFFFF_FFFF), .ID_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid[0]), .job_ready(job_ready[0]), .job_id(job_id),
        .job_seed(job_seed), .job_polynomial(job_polynomial), .job_mask_i(job_mask_i),
        .job_mask_o(job_mask_o), .job_limit(job_limit), .job_round_keys(job_round_keys),
        .blk_start(blk_start[0]), .blk_restart(blk_restart[0]), .blk_seed(blk_seed[0]),
        .blk_polynomial(blk_poly[0]), .blk_mask_i(blk_mask_i[0]), .blk_mask_o(blk_mask_o[0]),
        .blk_limit(blk_limit[0]), .blk_round_keys(blk_rk[0]), .blk_counter(blk_counter[0]),
        .blk_done(blk_done[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
        .res_id(res_id[0]), .res_counter(res_counter[0]), .res_cycles(res_cycles[0]),
        .res_timeout(res_timeout[0]), .busy(busy[0]), .jobs_done(jobs_done[0])
    );

    des_block_controller #(.TIMEOUT(32'd16), .ID_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid[1]), .job_ready(job_ready[1]), .job_id(job_id),
        .job_seed(job_seed), .job_polynomial(job_polynomial), .job_mask_i(job_mask_i),
        .job_mask_o(job_mask_o), .job_limit(job_limit), .job_round_keys(job_round_keys),
        .blk_start(blk_start[1]), .blk_restart(blk_restart[1]), .blk_seed(blk_seed[1]),
        .blk_polynomial(blk_poly[1]), .blk_mask_i(blk_mask_i[1]), .blk_mask_o(blk_mask_o[1]),
        .blk_limit(blk_limit[1]), .blk_round_keys(blk_rk[1]), .blk_counter(blk_counter[1]),
        .blk_done(blk_done[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
        .res_id(res_id[1]), .res_counter(res_counter[1]), .res_cycles(res_cycles[1]),
        .res_timeout(res_timeout[1]), .busy(busy[1]), .jobs_done(jobs_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // des_block model: run_k counts RUN cycles from 1; done pulses at RUN cycle done_at.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_k[0] <= 0;
            run_k[1] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (blk_start[i])        run_k[i] <= 1;
                else if (blk_restart[i]) run_k[i] <= 0;
                else if (run_k[i] != 0)  run_k[i] <= run_k[i] + 1;
            end
        end
    end

    assign blk_done[0]    = (done_at[0] != 0) && (run_k[0] == done_at[0]);
    assign blk_done[1]    = (done_at[1] != 0) && (run_k[1] == done_at[1]);
    assign blk_counter[0] = cnt_val[0];
    assign blk_counter[1] = cnt_val[1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pulse bookkeeping and scoreboard pops on every result handshake.
    initial begin
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (blk_start[i]) begin
                        start_cnt[i]++;
                        start_cyc[i] = cyc;
                    end
                    if (blk_restart[i]) restart_cnt[i]++;
                    if (res_valid[i] && res_ready[i]) begin
                        have = 1'b0;
                        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        chk("sb_expected_present", 64'(have), 64'd1);
                        if (have) begin
                            chk("sb_res_id", 64'(res_id[i]), 64'(e.id));
                            chk("sb_res_counter", res_counter[i], e.counter);
                            chk("sb_res_cycles", 64'(res_cycles[i]), 64'(e.cycles));
                            chk("sb_res_timeout", 64'(res_timeout[i]), 64'(e.timeout));
                        end
                    end
                end
            end
        end
    end

    task automatic set_params(input logic [7:0] id, input logic [63:0] limit);
        job_id         = id;
        job_seed       = 64'h5EED_0000_0000_0000 | {56'd0, id};
        job_polynomial = 64'hC0FF_EE00_0000_0000 | {56'd0, id};
        job_mask_i     = 64'h0000_0000_F0F0_0000 | {56'd0, id};
        job_mask_o     = 64'h0F0F_0000_0000_0000 | {56'd0, id};
        job_limit      = limit;
        job_round_keys = {12{job_seed ^ 64'h0000_0000_0000_FFFF}};
    endtask

    task automatic check_reset_state(input int inst, input string tag);
        chk({tag, "_job_ready"}, 64'(job_ready[inst]), 64'd1);
        chk({tag, "_busy"}, 64'(busy[inst]), 64'd0);
        chk({tag, "_blk_start"}, 64'(blk_start[inst]), 64'd0);
        chk({tag, "_blk_restart"}, 64'(blk_restart[inst]), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid[inst]), 64'd0);
        chk({tag, "_res_timeout"}, 64'(res_timeout[inst]), 64'd0);
        chk({tag, "_blk_seed"}, blk_seed[inst], 64'd0);
        chk({tag, "_blk_limit"}, blk_limit[inst], 64'd0);
        chk({tag, "_blk_mask_o"}, blk_mask_o[inst], 64'd0);
        chk({tag, "_blk_rk_zero"}, 64'(blk_rk[inst] == 768'd0), 64'd1);
        chk({tag, "_res_id"}, 64'(res_id[inst]), 64'd0);
        chk({tag, "_res_counter"}, res_counter[inst], 64'd0);
        chk({tag, "_res_cycles"}, 64'(res_cycles[inst]), 64'd0);
        chk({tag, "_jobs_done"}, 64'(jobs_done[inst]), 64'd0);
    endtask

    task automatic run_job(input int inst, input logic [7:0] id, input logic [63:0] limit,
                           input int dat, input logic [63:0] cnt, input logic [31:0] ecyc,
                           input logic eto, input int hold);
        exp_t        e;
        int          h, t, s0, r0, rv_off;
        logic [63:0] ecnt;
        @(posedge clk); #1;
        ecnt   = (limit == 64'd0) ? 64'd0 : cnt;
        rv_off = (limit == 64'd0) ? 1 : 3 + int'(ecyc);
        done_at[inst] = dat;
        cnt_val[inst] = cnt;
        set_params(id, limit);
        chk("job_ready_idle", 64'(job_ready[inst]), 64'd1);
        s0 = start_cnt[inst];
        r0 = restart_cnt[inst];
        e.id = id; e.counter = ecnt; e.cycles = ecyc; e.timeout = eto;
        if (inst == 0) q0.push_back(e); else q1.push_back(e);
        res_ready[inst] = (hold == 0);
        job_valid[inst] = 1'b1;
        h = cyc;
        @(posedge clk); #1;
        job_valid[inst] = 1'b0;
        chk("job_ready_after_accept", 64'(job_ready[inst]), 64'd0);
        chk("busy_after_accept", 64'(busy[inst]), 64'd1);
        chk("blk_seed", blk_seed[inst], job_seed);
        chk("blk_polynomial", blk_poly[inst], job_polynomial);
        chk("blk_mask_i", blk_mask_i[inst], job_mask_i);
        chk("blk_limit", blk_limit[inst], job_limit);
        chk("blk_round_keys_eq", 64'(blk_rk[inst] == job_round_keys), 64'd1);
        t = 0;
        while (!res_valid[inst] && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("res_valid_latency", 64'(cyc - h), 64'(rv_off));
        for (int k = 0; k < hold; k++) begin
            chk("bp_res_valid", 64'(res_valid[inst]), 64'd1);
            chk("bp_res_id", 64'(res_id[inst]), 64'(id));
            chk("bp_res_counter", res_counter[inst], ecnt);
            chk("bp_res_cycles", 64'(res_cycles[inst]), 64'(ecyc));
            chk("bp_res_timeout", 64'(res_timeout[inst]), 64'(eto));
            chk("bp_job_ready", 64'(job_ready[inst]), 64'd0);
            chk("bp_no_restart", 64'(blk_restart[inst]), 64'd0);
            @(posedge clk); #1;
        end
        res_ready[inst] = 1'b1;
        @(posedge clk); #1;
        chk("restart_high", 64'(blk_restart[inst]), 64'd1);
        chk("job_ready_in_clear", 64'(job_ready[inst]), 64'd0);
        chk("res_valid_dropped", 64'(res_valid[inst]), 64'd0);
        @(posedge clk); #1;
        res_ready[inst] = 1'b0;
        exp_jobs[inst]++;
        chk("restart_low", 64'(blk_restart[inst]), 64'd0);
        chk("job_ready_back", 64'(job_ready[inst]), 64'd1);
        chk("busy_idle", 64'(busy[inst]), 64'd0);
        chk("restart_pulses", 64'(restart_cnt[inst] - r0), 64'd1);
        chk("start_pulses", 64'(start_cnt[inst] - s0), (limit == 64'd0) ? 64'd0 : 64'd1);
        if (limit != 64'd0) chk("start_offset", 64'(start_cyc[inst] - h), 64'd2);
        chk("jobs_done", 64'(jobs_done[inst]), 64'(exp_jobs[inst]));
        chk("sb_drained", 64'((inst == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        int t, r0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            job_valid[i] = 1'b0; res_ready[i] = 1'b0; done_at[i] = 0; cnt_val[i] = 64'd0;
            start_cnt[i] = 0; start_cyc[i] = 0; restart_cnt[i] = 0; exp_jobs[i] = 0;
        end
        set_params(8'h00, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");
        @(negedge clk);
        rst_n = 1'b1;

        run_job(0, 8'h5A, 64'd100, 40, 64'd37, 32'd40, 1'b0, 0);
        run_job(0, 8'h3C, 64'd500, 7, 64'd1234, 32'd7, 1'b0, 10);
        run_job(1, 8'h77, 64'd100, 0, 64'd9, 32'd16, 1'b1, 0);
        run_job(1, 8'h88, 64'd100, 16, 64'd55, 32'd16, 1'b0, 0);
        run_job(1, 8'h11, 64'd3, 1, 64'd5, 32'd1, 1'b0, 0);
        run_job(0, 8'h0F, 64'd0, 3, 64'd99, 32'd0, 1'b0, 0);

        // Reset in the middle of RUN: no result, no restart pulse, state fully cleared.
        @(posedge clk); #1;
        done_at[0] = 0;
        cnt_val[0] = 64'd21;
        set_params(8'hC3, 64'd100);
        res_ready[0] = 1'b1;
        job_valid[0] = 1'b1;
        @(posedge clk); #1;
        job_valid[0] = 1'b0;
        t = 0;
        while (run_k[0] != 5 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("mid_run_reached", 64'(run_k[0]), 64'd5);
        chk("mid_run_busy", 64'(busy[0]), 64'd1);
        r0 = restart_cnt[0];
        rst_n = 1'b0;
        #1;
        check_reset_state(0, "async_rst");
        repeat (2) @(posedge clk);
        #1;
        chk("async_rst_no_restart", 64'(restart_cnt[0] - r0), 64'd0);
        chk("async_rst_restart_low", 64'(blk_restart[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        res_ready[0] = 1'b0;
        exp_jobs[0] = 0;
        exp_jobs[1] = 0;

        run_job(0, 8'hA5, 64'd50, 3, 64'd77, 32'd3, 1'b0, 0);
        chk("jobs_after_reset", 64'(jobs_done[0]), 64'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
